// File: rtl/jerk_pkg.sv
// jerk_pkg: mode encodings, FSM state type and first-target helper shared by jerk_seq
package jerk_pkg;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_BNC  = 2'b10;
    localparam logic [1:0] MODE_RING = 2'b11;

    typedef enum logic {HOME, EXCUR} state_t;

    // Reverse sweeps start at the top bit; every other mode starts at bit 1.
    function automatic int first_target(input logic [1:0] m, input int width);
        return (m == MODE_REV) ? width - 1 : 1;
    endfunction

endpackage

// File: rtl/jerk_dwell_timer.sv
// jerk_dwell_timer: holds each sequencer value for dwell+1 enabled cycles and flags the step
module jerk_dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);

    logic [DWELL_W-1:0] cnt_q, cnt_d, lim_q, lim_d;

    assign tick = enable && (cnt_q == lim_q);

    // Count enabled cycles; clear and re-latch the hold length on every step.
    always_comb begin
        cnt_d = tick ? '0 : enable ? cnt_q + DWELL_W'(1) : cnt_q;
        lim_d = tick ? dwell : lim_q;
    end

    // Reset starts a fresh hold using the dwell value present at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lim_q <= dwell;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/jerk_seq.sv
// jerk_seq: parametrised one-hot jerk sequencer with sweep modes, dwell and status flags
module jerk_seq
    import jerk_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int DWELL_W = 4,
    localparam int PW      = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   count,
    output logic [PW-1:0]      pos,
    output logic               at_home,
    output logic               step,
    output logic               wrap
);

    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] TWO  = PW'(2);

    logic             tick;
    state_t           state_q, state_d;
    logic [PW-1:0]    target_q, target_d, pos_q, pos_d;
    logic             dir_q, dir_d, wrap_d, step_q, wrap_q;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] count_q;

    jerk_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dwell  (dwell),
        .tick   (tick)
    );

    // Next position, target, direction and mode latch; a sweep end reloads the new mode's first target.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        pos_d    = pos_q;
        wrap_d   = 1'b0;
        if (tick) begin
            if (mode_q == MODE_RING) begin
                pos_d  = (pos_q == LAST) ? '0 : pos_q + ONE;
                wrap_d = pos_q == LAST;
            end else if (state_q == HOME) begin
                pos_d   = target_q;
                state_d = EXCUR;
            end else begin
                pos_d    = '0;
                state_d  = HOME;
                dir_d    = (mode_q == MODE_BNC && target_q == LAST) ? 1'b0 : dir_q;
                target_d = (mode_q == MODE_REV || !dir_d) ? target_q - ONE : target_q + ONE;
                wrap_d   = (mode_q == MODE_FWD) ? target_q == LAST :
                           (mode_q == MODE_REV) ? target_q == ONE :
                           (WIDTH <= 3)         ? target_q == LAST :
                                                  !dir_q && target_q == TWO;
            end
            if (wrap_d) begin
                mode_d   = mode;
                target_d = PW'(first_target(mode, WIDTH));
                dir_d    = 1'b1;
                state_d  = HOME;
            end
        end
    end

    // Sequencer state and registered outputs; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HOME;
            target_q <= PW'(first_target(mode, WIDTH));
            dir_q    <= 1'b1;
            mode_q   <= mode;
            pos_q    <= '0;
            count_q  <= WIDTH'(1);
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            count_q  <= WIDTH'(1) << pos_d;
            step_q   <= tick;
            wrap_q   <= wrap_d;
        end
    end

    assign count   = count_q;
    assign pos     = pos_q;
    assign at_home = pos_q == '0;
    assign step    = step_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_jerk_seq.sv
// tb_jerk_seq: scoreboard bench for jerk_seq at widths 8, 5 and 4
module tb_jerk_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] dwell = 4'd0;

    logic [7:0] c8; logic [2:0] p8; logic h8, s8, w8;
    logic [4:0] c5; logic [2:0] p5; logic h5, s5, w5;
    logic [3:0] c4; logic [1:0] p4; logic h4, s4, w4;

    always #5 clk = ~clk;

    jerk_seq #(.WIDTH(8), .DWELL_W(4)) u8 (.clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .dwell(dwell), .count(c8), .pos(p8), .at_home(h8), .step(s8), .wrap(w8));
    jerk_seq #(.WIDTH(5), .DWELL_W(4)) u5 (.clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .dwell(dwell), .count(c5), .pos(p5), .at_home(h5), .step(s5), .wrap(w5));
    jerk_seq #(.WIDTH(4), .DWELL_W(4)) u4 (.clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .dwell(dwell), .count(c4), .pos(p4), .at_home(h4), .step(s4), .wrap(w4));

    int sel = 8;
    logic [31:0] o_count, o_pos;
    logic        o_home, o_step, o_wrap;

    always_comb begin
        o_count = sel == 8 ? 32'(c8) : sel == 5 ? 32'(c5) : 32'(c4);
        o_pos   = sel == 8 ? 32'(p8) : sel == 5 ? 32'(p5) : 32'(p4);
        o_home  = sel == 8 ? h8 : sel == 5 ? h5 : h4;
        o_step  = sel == 8 ? s8 : sel == 5 ? s5 : s4;
        o_wrap  = sel == 8 ? w8 : sel == 5 ? w5 : w4;
    end

    typedef struct { int p; bit w; } ent_t;
    typedef struct { int c; int p; bit s; bit w; } exp_t;

    ent_t plan[$];
    exp_t sb[$];
    int m_cur, m_cnt, m_lat, m_mode;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s sel=%0d got=%0h exp=%0h at %0t", tag, sel, got, exp, $time);
    endtask

    // One sweep as a list of positions; the home entry that closes the sweep carries w=1.
    task automatic build(input int md, input int w);
        int tg[$];
        if (md == 1) for (int t = w - 1; t >= 1; t--) tg.push_back(t);
        else begin
            for (int t = 1; t <= w - 1; t++) tg.push_back(t);
            if (md == 2) for (int t = w - 2; t >= 2; t--) tg.push_back(t);
        end
        foreach (tg[i]) begin
            plan.push_back('{tg[i], 1'b0});
            if (md != 3) plan.push_back('{0, i == tg.size() - 1});
        end
        if (md == 3) plan.push_back('{0, 1'b1});
    endtask

    task automatic model();
        ent_t e;
        exp_t x;
        x = '{1 << m_cur, m_cur, 1'b0, 1'b0};
        if (reset) begin
            m_cur = 0; m_cnt = 0; m_lat = int'(dwell); m_mode = int'(mode);
            plan.delete();
            x = '{1, 0, 1'b0, 1'b0};
        end else if (enable && m_cnt == m_lat) begin
            m_cnt = 0;
            m_lat = int'(dwell);
            if (plan.size() == 0) build(m_mode, sel);
            e = plan.pop_front();
            m_cur = e.p;
            if (e.w) m_mode = int'(mode);
            x = '{1 << m_cur, m_cur, 1'b1, e.w};
        end else if (enable) m_cnt++;
        sb.push_back(x);
    endtask

    task automatic cyc();
        exp_t x;
        model();
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("count", int'(o_count), x.c);
        chk("pos", int'(o_pos), x.p);
        chk("at_home", int'(o_home), int'(x.c == 1));
        chk("step", int'(o_step), int'(x.s));
        chk("wrap", int'(o_wrap), int'(x.w));
    endtask

    task automatic start(input int s, input logic [1:0] md, input logic [3:0] dw);
        sel = s; mode = md; dwell = dw; enable = 1'b1; reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_count(input int v, input int lim);
        int k = 0;
        while (int'(o_count) != v && k < lim) begin
            cyc();
            k++;
        end
        chk("wait_count", int'(o_count), v);
    endtask

    logic [7:0] reg_tbl [16] = '{8'h01, 8'h02, 8'h01, 8'h04, 8'h01, 8'h08, 8'h01, 8'h10,
                                 8'h01, 8'h20, 8'h01, 8'h40, 8'h01, 8'h80, 8'h01, 8'h02};
    logic [3:0] sw_tbl [8] = '{4'h1, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

    initial begin
        int nw, ns, held;
        sel = 8;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) reset = 1'b0;
            cyc();
            chk("reg_tbl", int'(o_count), int'(reg_tbl[i]));
            chk("reg_wrap", int'(o_wrap), int'(i == 14));
        end
        repeat (30) cyc();

        start(8, 2'b01, 4'd2);
        nw = 0; ns = 0;
        repeat (84) begin
            cyc();
            nw += int'(o_wrap);
            ns += int'(o_step);
        end
        chk("rev_wraps", nw, 2);
        chk("rev_steps", ns, 28);

        start(5, 2'b10, 4'd0);
        repeat (40) cyc();

        start(4, 2'b00, 4'd0);
        wait_count(4, 20);
        mode = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("sw_tbl", int'(o_count), int'(sw_tbl[i]));
            chk("sw_wrap", int'(o_wrap), int'(i == 2 || i == 6));
        end

        start(8, 2'b00, 4'd3);
        repeat (9) cyc();
        held = int'(o_count);
        enable = 1'b0;
        repeat (5) begin
            cyc();
            chk("frz_count", int'(o_count), held);
            chk("frz_step", int'(o_step), 0);
        end
        enable = 1'b1;
        repeat (30) cyc();

        start(8, 2'b00, 4'd0);
        wait_count(32'h20, 40);
        reset = 1'b1;
        cyc();
        chk("rst_count", int'(o_count), 1);
        chk("rst_wrap", int'(o_wrap), 0);
        reset = 1'b0;
        cyc();
        chk("rst_next", int'(o_count), 2);

        foreach (reg_tbl[k]) if (k < 3) begin
            start(k == 0 ? 8 : k == 1 ? 5 : 4, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 2)));
            repeat (300) begin
                enable = $urandom_range(0, 5) != 0;
                mode = 2'($urandom_range(0, 3));
                dwell = 4'($urandom_range(0, 3));
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jerk_seq.md
Name: jerk_seq

Overview:
Parametrised "jerk" one-hot sequencer: the lit bit returns to home (bit 0) between every excursion to a walking position. Successor to the fixed 8-bit jerk counter. Adds:
- configurable width
- four sweep modes: forward, reverse, bounce, plain ring
- per-step dwell time
- enable/freeze
- status outputs for downstream LED/scan drivers

Parameters:
WIDTH, 8, number of one-hot output bits; legal range 2..32.
DWELL_W, 4, width of dwell input; each output value is held dwell+1 enabled cycles.
PW, $clog2(WIDTH), localparam; width of position index (derived, not overridable).

Ports:
clk    input  1        clock, all logic on rising edge
reset  input  1        synchronous, active-high
enable input  1        1 = sequencer advances; 0 = freeze all state, including the dwell counter
mode   input  2        sweep mode; encodings in jerk_pkg; sampled only at sweep boundaries
dwell  input  DWELL_W  hold length minus 1; sampled on every step
count  output WIDTH    one-hot pattern, registered
pos    output PW       index of the lit bit in count (0 at home)
at_home output 1       count == 1
step   output 1        1-cycle pulse in the cycle after count changes value
wrap   output 1        1-cycle pulse on the first cycle of the home value that ends a sweep

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. Reset has priority over enable.
- Reset response (next edge with reset=1):
  - count=1, pos=0, at_home=1, step=0, wrap=0
  - dwell counter=0, direction=up
  - mode latched from the mode input
  - next excursion target = first position of the latched mode
- Reset mid-sweep or mid-dwell abandons the sweep. No wrap is generated.
- Step condition: enable=1 and dwell counter == latched dwell. On a step, the counter clears and the dwell input is re-latched. Otherwise, with enable=1, the counter increments.
- With dwell=0 and enable=1, count changes every cycle. Step latency is 1 clock.
- Jerk modes (FWD, REV, BNC), on each step:
  - from home: go to bit target
  - from an excursion: go back to home and advance target
- FWD targets: 1,2,..,WIDTH-1, then 1. The sweep ends on the home return after target WIDTH-1.
- REV targets: WIDTH-1,..,1, then WIDTH-1. The sweep ends on the home return after target 1.
- BNC targets: 1,2,..,WIDTH-1,WIDTH-2,..,2, then 1. Direction flips at the endpoints and endpoints are not repeated.
  - For WIDTH>=4, the sweep ends on the home return after target 2 while descending.
  - For WIDTH<=3, the sweep ends after target WIDTH-1.
- RING mode: no home interleave. Count rotates 1<<0 .. 1<<(WIDTH-1) and back to 1<<0. The sweep ends on the return to bit 0.
- Sweep boundary:
  - wrap=1 for exactly one cycle, aligned with the first cycle count==1. It is not repeated during a dwell hold.
  - A new mode is latched at this edge; the first target of the new mode follows.
  - Mode changes mid-sweep are ignored until the boundary.
- WIDTH=2: all jerk modes produce 1,2,1,2,... and wrap on every home return.
- enable=0: count, pos, the dwell counter and direction all hold; step=0 and wrap=0.
- Regression requirement: WIDTH=8, FWD, dwell=0 must reproduce 01,02,01,04,01,08,..,01,80,01,02,... exactly, starting with 01 in the reset cycle.

Decomposition:
- jerk_pkg holds:
  - mode localparams: MODE_FWD=2'b00, MODE_REV=2'b01, MODE_BNC=2'b10, MODE_RING=2'b11
  - a function computing the first target for a mode given WIDTH
- Sub-module jerk_dwell_timer (DWELL_W), ports clk, reset, enable, dwell, tick:
  - owns the dwell counter and dwell latch
  - asserts tick for the step condition
- The top level holds:
  - the target/direction/mode-latch FSM, with states HOME and EXCUR
  - the count/pos/flag registers

Test Plan:
- WIDTH=8, FWD, dwell=0, reset 1 cycle -> count 01,02,01,04,..,01,80,01,02; wrap only on the 01 after 80, period 14 cycles.
- WIDTH=8, REV, dwell=2 -> each value held 3 cycles: 01x3,80x3,01x3,40x3,..; step pulses every 3rd cycle; wrap once per 42 cycles.
- WIDTH=5, BNC, dwell=0 -> 01,02,01,04,01,08,01,10,01,08,01,04,01,02(wrap on the next 01)... then 02,01,04.
- WIDTH=4, switch from FWD to RING mid-sweep at count=04 -> FWD completes (01,08,01 with wrap), then 02,04,08,01(wrap),02.
- enable held 0 for 5 cycles mid-dwell -> count, pos and the dwell phase are frozen; the sequence resumes exactly where it stopped; no step/wrap during the freeze.
- Reset asserted while count=20 (WIDTH=8, FWD) -> next edge count=01, wrap=0, then 02.
